// File: rtl/calc_sequencer.sv
// Control FSM for the calculator: turns keypad pulses into holder commands and times the ALU execute window.
// Latency: commands are registered (event at edge N -> Sel valid N..N+1); result commit EXEC_CYCLES edges after Eq.
// Backpressure: none; pulses that arrive while busy or are outranked in their cycle are dropped, not queued.
module calc_sequencer #(
    parameter int EXEC_CYCLES = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       NumValid,
    input  logic       OpValid,
    input  logic [1:0] OpIn,
    input  logic       Eq,
    input  logic       Clr,
    output logic [2:0] Sel,
    output logic [1:0] AluOp,
    output logic       Busy,
    output logic       Done
);

    localparam logic [2:0] ST_INIT   = 3'd0;
    localparam logic [2:0] ST_IDLE   = 3'd1;
    localparam logic [2:0] ST_HAVE_A = 3'd2;
    localparam logic [2:0] ST_WAIT_B = 3'd3;
    localparam logic [2:0] ST_HAVE_B = 3'd4;
    localparam logic [2:0] ST_EXEC   = 3'd5;
    localparam logic [2:0] ST_SHOW   = 3'd6;

    localparam logic [2:0] SEL_HOLD   = 3'b000;
    localparam logic [2:0] SEL_LD_A   = 3'b001;
    localparam logic [2:0] SEL_LD_B   = 3'b010;
    localparam logic [2:0] SEL_LD_RES = 3'b011;
    localparam logic [2:0] SEL_CLR    = 3'b100;

    // Counter is loaded with EXEC_CYCLES-1 so that commit lands exactly EXEC_CYCLES edges after Eq.
    localparam logic [3:0] CNT_LOAD = 4'(EXEC_CYCLES - 1);

    logic [2:0] state_q, state_d;
    logic [2:0] sel_q, sel_d;
    logic [1:0] alu_op_q, alu_op_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic [3:0] cnt_q, cnt_d;
    logic       chain_q, chain_d;
    logic [1:0] pend_q, pend_d;

    // Priority-resolved events: only the highest-ranked pulse of a cycle survives (Clr handled separately).
    logic ev_eq, ev_op, ev_num;
    assign ev_eq  = Eq;
    assign ev_op  = OpValid & ~Eq;
    assign ev_num = NumValid & ~OpValid & ~Eq;

    // Next-state and command decode.
    always_comb begin
        state_d  = state_q;
        sel_d    = SEL_HOLD;
        alu_op_d = alu_op_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        cnt_d    = cnt_q;
        chain_d  = chain_q;
        pend_d   = pend_q;

        if (state_q != ST_INIT && Clr) begin
            state_d  = ST_IDLE;
            sel_d    = SEL_CLR;
            alu_op_d = 2'b00;
            busy_d   = 1'b0;
            chain_d  = 1'b0;
            cnt_d    = 4'd0;
        end else begin
            case (state_q)
                ST_INIT: begin
                    sel_d   = SEL_CLR;
                    state_d = ST_IDLE;
                end
                ST_IDLE: begin
                    if (ev_num) begin
                        sel_d   = SEL_LD_A;
                        state_d = ST_HAVE_A;
                    end
                end
                ST_HAVE_A: begin
                    if (ev_op) begin
                        alu_op_d = OpIn;
                        state_d  = ST_WAIT_B;
                    end else if (ev_num) begin
                        sel_d = SEL_LD_A;
                    end
                end
                ST_WAIT_B: begin
                    if (ev_op) begin
                        alu_op_d = OpIn;
                    end else if (ev_num) begin
                        sel_d   = SEL_LD_B;
                        state_d = ST_HAVE_B;
                    end
                end
                ST_HAVE_B: begin
                    if (ev_eq) begin
                        state_d = ST_EXEC;
                        busy_d  = 1'b1;
                        cnt_d   = CNT_LOAD;
                    end else if (ev_op) begin
                        // Chained operator: current op executes now, the new one is applied at commit.
                        pend_d  = OpIn;
                        chain_d = 1'b1;
                        state_d = ST_EXEC;
                        busy_d  = 1'b1;
                        cnt_d   = CNT_LOAD;
                    end else if (ev_num) begin
                        sel_d = SEL_LD_B;
                    end
                end
                ST_EXEC: begin
                    if (cnt_q == 4'd0) begin
                        sel_d  = SEL_LD_RES;
                        done_d = 1'b1;
                        busy_d = 1'b0;
                        if (chain_q) begin
                            alu_op_d = pend_q;
                            chain_d  = 1'b0;
                            state_d  = ST_WAIT_B;
                        end else begin
                            state_d = ST_SHOW;
                        end
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end
                ST_SHOW: begin
                    if (ev_eq) begin
                        // Repeat-equals: HolderB and AluOp are reused as-is.
                        state_d = ST_EXEC;
                        busy_d  = 1'b1;
                        cnt_d   = CNT_LOAD;
                    end else if (ev_op) begin
                        alu_op_d = OpIn;
                        state_d  = ST_WAIT_B;
                    end else if (ev_num) begin
                        sel_d   = SEL_LD_A;
                        state_d = ST_HAVE_A;
                    end
                end
                default: begin
                    state_d = ST_INIT;
                end
            endcase
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= ST_INIT;
            sel_q    <= SEL_HOLD;
            alu_op_q <= 2'b00;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            cnt_q    <= 4'd0;
            chain_q  <= 1'b0;
            pend_q   <= 2'b00;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            alu_op_q <= alu_op_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            cnt_q    <= cnt_d;
            chain_q  <= chain_d;
            pend_q   <= pend_d;
        end
    end

    assign Sel   = sel_q;
    assign AluOp = alu_op_q;
    assign Busy  = busy_q;
    assign Done  = done_q;

endmodule

// File: tb/tb_calc_sequencer.sv
// Bench for calc_sequencer: directed scenarios plus random key streams against a calculator-level model.
// Every cycle Sel/AluOp/Busy/Done are compared with the model; directed steps add fixed expectations.
// Inputs change 1ns after the rising edge; outputs are sampled at the same point.
module tb_calc_sequencer;

    localparam int E = 4;

    logic       clock = 1'b0;
    logic       reset;
    logic       NumValid;
    logic       OpValid;
    logic [1:0] OpIn;
    logic       Eq;
    logic       Clr;
    logic [2:0] Sel;
    logic [1:0] AluOp;
    logic       Busy;
    logic       Done;

    calc_sequencer #(.EXEC_CYCLES(E)) dut (
        .clock    (clock),
        .reset    (reset),
        .NumValid (NumValid),
        .OpValid  (OpValid),
        .OpIn     (OpIn),
        .Eq       (Eq),
        .Clr      (Clr),
        .Sel      (Sel),
        .AluOp    (AluOp),
        .Busy     (Busy),
        .Done     (Done)
    );

    always #5 clock = ~clock;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Calculator-level view: what has been keyed in, and how long until the result is ready.
    bit         m_init;
    bit         m_have_a;
    bit         m_have_op;
    bit         m_have_b;
    bit         m_showing;
    bit         m_chain;
    int         m_left;
    logic [1:0] m_pend;
    logic [2:0] e_sel  = 3'd0;
    logic [1:0] e_op   = 2'd0;
    logic       e_busy = 1'b0;
    logic       e_done = 1'b0;

    task automatic clear_all();
        m_have_a  = 0;
        m_have_op = 0;
        m_have_b  = 0;
        m_showing = 0;
        m_chain   = 0;
        m_left    = 0;
        e_op      = 2'd0;
        e_busy    = 1'b0;
    endtask

    task automatic start_exec();
        m_left    = E;
        e_busy    = 1'b1;
        m_showing = 0;
    endtask

    task automatic model_step();
        e_sel  = 3'd0;
        e_done = 1'b0;
        if (reset) begin
            clear_all();
            m_init = 1;
        end else if (m_init) begin
            m_init = 0;
            e_sel  = 3'd4;
        end else if (Clr) begin
            clear_all();
            e_sel = 3'd4;
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0) begin
                e_sel  = 3'd3;
                e_done = 1'b1;
                e_busy = 1'b0;
                if (m_chain) begin
                    e_op     = m_pend;
                    m_chain  = 0;
                    m_have_b = 0;
                end else begin
                    m_showing = 1;
                end
            end
        end else if (Eq) begin
            if (m_have_b) start_exec();
        end else if (OpValid) begin
            if (m_showing) begin
                e_op      = OpIn;
                m_have_b  = 0;
                m_showing = 0;
            end else if (m_have_b) begin
                m_pend  = OpIn;
                m_chain = 1;
                start_exec();
            end else if (m_have_a) begin
                e_op      = OpIn;
                m_have_op = 1;
            end
        end else if (NumValid) begin
            if (m_showing) begin
                e_sel     = 3'd1;
                m_have_op = 0;
                m_have_b  = 0;
                m_showing = 0;
            end else if (m_have_b) begin
                e_sel = 3'd2;
            end else if (m_have_op) begin
                e_sel    = 3'd2;
                m_have_b = 1;
            end else begin
                e_sel    = 3'd1;
                m_have_a = 1;
            end
        end
    endtask

    task automatic cyc(input bit n, input bit o, input logic [1:0] oi, input bit q, input bit c, input bit r);
        NumValid = n;
        OpValid  = o;
        OpIn     = oi;
        Eq       = q;
        Clr      = c;
        reset    = r;
        @(posedge clock);
        model_step();
        #1;
        chk("sel",   32'(Sel),   32'(e_sel));
        chk("aluop", 32'(AluOp), 32'(e_op));
        chk("busy",  32'(Busy),  32'(e_busy));
        chk("done",  32'(Done),  32'(e_done));
    endtask

    task automatic idle(input int k);
        repeat (k) cyc(0, 0, 2'd0, 0, 0, 0);
    endtask

    task automatic num();
        cyc(1, 0, 2'd0, 0, 0, 0);
    endtask

    task automatic op(input logic [1:0] code);
        cyc(0, 1, code, 0, 0, 0);
    endtask

    task automatic eq();
        cyc(0, 0, 2'd0, 1, 0, 0);
    endtask

    task automatic clr();
        cyc(0, 0, 2'd0, 0, 1, 0);
    endtask

    task automatic rst();
        cyc(0, 0, 2'd0, 0, 0, 1);
    endtask

    initial begin
        // Reset, then the one-cycle holder clear.
        rst();
        rst();
        chk("rst_sel", 32'(Sel), 0);
        idle(1);
        chk("init_clr", 32'(Sel), 4);
        idle(1);
        chk("idle_hold", 32'(Sel), 0);
        chk("idle_aluop", 32'(AluOp), 0);

        // Basic add: Busy for E cycles, commit E edges after Eq.
        num();
        chk("add_lda", 32'(Sel), 1);
        op(2'd0);
        num();
        chk("add_ldb", 32'(Sel), 2);
        eq();
        chk("add_busy_start", 32'(Busy), 1);
        for (int i = 1; i < E; i++) begin
            idle(1);
            chk("add_busy_mid", 32'(Busy), 1);
            chk("add_no_early_done", 32'(Done), 0);
        end
        idle(1);
        chk("add_res", 32'(Sel), 3);
        chk("add_done", 32'(Done), 1);
        chk("add_busy_end", 32'(Busy), 0);
        idle(1);
        chk("add_done_pulse", 32'(Done), 0);

        // Repeat-equals from SHOW.
        eq();
        chk("rep_busy", 32'(Busy), 1);
        idle(E - 1);
        idle(1);
        chk("rep_res", 32'(Sel), 3);
        chk("rep_op", 32'(AluOp), 0);

        // Chained operator: mul executes, sub becomes pending op.
        num();
        op(2'd2);
        num();
        op(2'd1);
        chk("chain_busy", 32'(Busy), 1);
        chk("chain_op_hold", 32'(AluOp), 2);
        idle(E - 1);
        idle(1);
        chk("chain_res", 32'(Sel), 3);
        chk("chain_op", 32'(AluOp), 1);
        num();
        chk("chain_ldb", 32'(Sel), 2);

        // Eq and NumValid together in HAVE_B, then pulses during EXEC are dropped.
        cyc(1, 0, 2'd0, 1, 0, 0);
        chk("eqnum_sel", 32'(Sel), 0);
        chk("eqnum_busy", 32'(Busy), 1);
        cyc(1, 0, 2'd0, 0, 0, 0);
        cyc(0, 1, 2'd3, 0, 0, 0);
        cyc(0, 0, 2'd0, 1, 0, 0);
        chk("exec_ign_sel", 32'(Sel), 0);
        chk("exec_ign_op", 32'(AluOp), 1);
        idle(1);
        chk("exec_ign_done", 32'(Done), 1);

        // Clr and Eq together in SHOW.
        cyc(0, 0, 2'd0, 1, 1, 0);
        chk("clreq_sel", 32'(Sel), 4);
        chk("clreq_busy", 32'(Busy), 0);
        chk("clreq_op", 32'(AluOp), 0);
        eq();
        chk("idle_eq_ign", 32'(Busy), 0);

        // Clr two cycles into EXEC.
        num();
        op(2'd3);
        num();
        eq();
        idle(2);
        clr();
        chk("abort_sel", 32'(Sel), 4);
        chk("abort_busy", 32'(Busy), 0);
        for (int i = 0; i < E + 2; i++) begin
            idle(1);
            chk("abort_no_done", 32'(Done), 0);
        end

        // Clr coincident with counter expiry.
        num();
        op(2'd1);
        num();
        eq();
        idle(E - 1);
        clr();
        chk("clr_expiry_sel", 32'(Sel), 4);
        chk("clr_expiry_done", 32'(Done), 0);

        // Reset mid-EXEC.
        num();
        op(2'd0);
        num();
        eq();
        idle(2);
        rst();
        chk("rst_exec_busy", 32'(Busy), 0);
        chk("rst_exec_sel", 32'(Sel), 0);
        idle(1);
        chk("rst_exec_clr", 32'(Sel), 4);
        for (int i = 0; i < E + 1; i++) begin
            idle(1);
            chk("rst_exec_no_done", 32'(Done), 0);
        end

        // Random key streams.
        for (int i = 0; i < 3000; i++) begin
            cyc($urandom_range(0, 3) == 0,
                $urandom_range(0, 4) == 0,
                2'($urandom_range(0, 3)),
                $urandom_range(0, 5) == 0,
                $urandom_range(0, 29) == 0,
                $urandom_range(0, 99) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/calc_sequencer.md
# calc_sequencer

Control FSM for the calculator datapath. It turns one-cycle key events (operand entered, operator, equals, clear) into the 3-bit `Sel` command bus shared by the operand holders. It also latches the ALU operation code and times the ALU's multi-cycle execute window. It sits between the keypad decoder and the HolderA / HolderB / ALU datapath.

## Interface
- EXEC_CYCLES, 4, ALU execute latency in clock cycles (legal range 1..15).
- clock  input  1  system clock, all state changes on the rising edge.
- reset  input  1  synchronous, active-high reset.
- NumValid  input  1  one-cycle pulse: the operand on the data bus is valid this cycle.
- OpValid  input  1  one-cycle pulse: operator key pressed, code on `OpIn`.
- OpIn  input  2  operator code: 00 add, 01 sub, 10 mul, 11 div.
- Eq  input  1  one-cycle pulse: equals key.
- Clr  input  1  one-cycle pulse: clear key.
- Sel  output  3  holder command (registered): 000 hold, 001 load HolderA from bus, 010 load HolderB from bus, 011 load ALU result into HolderA, 100 clear holders.
- AluOp  output  2  latched operator driven to the ALU.
- Busy  output  1  high while the ALU execute window is running.
- Done  output  1  one-cycle pulse in the cycle the result is committed (Sel=011).

## Operation
- States: INIT, IDLE, HAVE_A, WAIT_B, HAVE_B, EXEC, SHOW.
- Event priority when several pulses arrive in the same cycle: Clr > Eq > OpValid > NumValid. Lower-priority events in that cycle are dropped.
- In every state except INIT, Clr forces the following, then goes to IDLE:
  - Sel=100 for one cycle.
  - AluOp=00, Busy=0.
  - Any pending chain cancelled.
- INIT: issue Sel=100 for one cycle, then go to IDLE.
- IDLE: NumValid -> Sel=001, go to HAVE_A. All other events are ignored.
- HAVE_A:
  - NumValid -> Sel=001, stay (operand overwritten).
  - OpValid -> AluOp<=OpIn, go to WAIT_B.
  - Eq is ignored.
- WAIT_B:
  - NumValid -> Sel=010, go to HAVE_B.
  - OpValid -> AluOp<=OpIn, stay.
  - Eq is ignored.
- HAVE_B:
  - NumValid -> Sel=010, stay.
  - Eq -> go to EXEC, Busy=1, counter<=EXEC_CYCLES-1.
  - OpValid (chained op) -> record OpIn as the pending op, set the chain flag, go to EXEC as for Eq.
- EXEC:
  - The counter decrements each cycle.
  - NumValid, OpValid and Eq are ignored (dropped, not queued).
  - When the counter reaches 0, do all of the following in the same cycle:
    - Sel=011 and Done=1.
    - Busy falls on the next cycle.
    - If the chain flag is set: AluOp<=pending op, clear the flag, go to WAIT_B.
    - Otherwise go to SHOW.
- SHOW:
  - NumValid -> Sel=001, go to HAVE_A (start fresh).
  - OpValid -> AluOp<=OpIn, go to WAIT_B (the result is already in HolderA and becomes operand A).
  - Eq -> repeat the operation: go to EXEC with the same AluOp; HolderB is unchanged.
- Commands other than those listed above: Sel=000.
- Every non-000 Sel value lasts exactly one cycle.

## Timing
- Reset values: Sel=000, AluOp=00, Busy=0, Done=0, chain flag=0, state=INIT.
- The first cycle after reset is released drives Sel=100, which clears the holders. HolderB has no reset of its own.
- An event sampled at edge N gives a Sel command valid from edge N to N+1. The holder loads at edge N+1.
  - The keypad decoder must therefore hold the data bus stable through edge N+1.
- Eq sampled at edge N:
  - Busy goes high after edge N.
  - Sel=011 and Done appear after edge N+EXEC_CYCLES.
- For EXEC_CYCLES=1: Eq at edge N gives Sel=011 after edge N+1.
- Reset asserted mid-EXEC: the next edge returns to INIT with Busy=0.
  - No Sel=011 or Done is emitted.
  - Then Sel=100 follows.
- Clr and counter expiry in the same cycle: Clr wins. No Done, Sel=100.

## Test plan
- Reset, then idle: after reset deasserts -> Sel=100 for one cycle, then 000. Busy=0, Done=0, AluOp=00.
- Basic add, EXEC_CYCLES=4:
  - Stimulus: NumValid, OpValid(00), NumValid, Eq on separate cycles.
  - Sel sequence: 001, 010.
  - Busy is high for 4 cycles.
  - Sel=011 with Done one-cycle pulse exactly 4 cycles after Eq is sampled.
- Chained op:
  - Stimulus: A, mul (10), B, then OpValid(01) instead of Eq.
  - After EXEC: Sel=011, AluOp becomes 01, state WAIT_B.
  - Next NumValid -> Sel=010.
- Simultaneous events:
  - Eq and NumValid in the same cycle in HAVE_B -> EXEC entered, no Sel=010.
  - Clr and Eq together -> Sel=100, IDLE.
- Inputs during EXEC: NumValid/OpValid/Eq pulses while Busy=1 -> no Sel change, AluOp unchanged, Done on time.
- Abort paths:
  - Clr two cycles into EXEC -> Sel=100, Busy=0 next cycle, no Done.
  - Reset mid-EXEC -> INIT, then Sel=100, no Done.
- Repeat-equals: Eq in SHOW -> second EXEC window of EXEC_CYCLES with the same AluOp, then Sel=011 again.
